ucie_ctl_stack_state_arb: RTL

//  Multi-stack FDI-to-RDI state arbiter for the UCIe adapter controller, sitting between N protocol-stack
//  FDI ports and the single RDI. It resolves the per-stack lp_state_req values into one RDI request and

---
 rtl/ucie_ctl_stack_state_arb_if.sv | 27 ++
 rtl/ucie_ctl_stack_state_arb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_stack_state_arb_if.sv
// FDI/RDI state-handshake bundle between the protocol stacks, the PHY and the state arbiter.
// The master side drives stack requests, link errors and PHY status; the slave side is the arbiter.
interface ucie_ctl_stack_state_arb_if #(
  parameter int unsigned NUM_STACKS = 2
);
  logic [4*NUM_STACKS-1:0] i_fdi_lp_state_req;
  logic [NUM_STACKS-1:0]   i_fdi_lp_linkerror;
  logic [3:0]              i_rdi_pl_state_sts;
  logic [3:0]              o_rdi_lp_state_req;
  logic                    o_rdi_lp_linkerror;
  logic [4*NUM_STACKS-1:0] o_fdi_pl_state_sts;
  logic [NUM_STACKS-1:0]   o_req_done;
  logic                    o_timeout;
  logic                    o_busy;

  modport master (
    output i_fdi_lp_state_req, i_fdi_lp_linkerror, i_rdi_pl_state_sts,
    input  o_rdi_lp_state_req, o_rdi_lp_linkerror, o_fdi_pl_state_sts,
    input  o_req_done, o_timeout, o_busy
  );

  modport slave (
    input  i_fdi_lp_state_req, i_fdi_lp_linkerror, i_rdi_pl_state_sts,
    output o_rdi_lp_state_req, o_rdi_lp_linkerror, o_fdi_pl_state_sts,
    output o_req_done, o_timeout, o_busy
  );
endinterface

// File: rtl/ucie_ctl_stack_state_arb.sv
// Multi-stack FDI-to-RDI state arbiter: resolves per-stack state requests into one RDI request,
// holds it until the PHY status matches, a link error aborts it, or the wait times out.
module ucie_ctl_stack_state_arb #(
  parameter int unsigned NUM_STACKS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  ucie_ctl_stack_state_arb_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] CODE_NOP      = 4'b0000;
  localparam logic [3:0] CODE_ACTIVE   = 4'b0001;
  localparam logic [3:0] CODE_L1       = 4'b0100;
  localparam logic [3:0] CODE_L2       = 4'b1000;
  localparam logic [3:0] CODE_LINKRST  = 4'b1001;
  localparam logic [3:0] CODE_LINKERR  = 4'b1010;
  localparam logic [3:0] CODE_RETRAIN  = 4'b1011;
  localparam logic [3:0] CODE_DISABLED = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [3:0]            target, target_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_STACKS-1:0] done_n;
  logic                  timeout_n;
  logic [3:0]            sts_q;
  logic [3:0]            resolved;
  logic                  any_dis, any_lr, any_rt, any_act, all_l2, all_pm;

  // Unlisted request codes collapse to NOP before arbitration.
  function automatic logic [3:0] norm_req(input logic [3:0] code);
    logic [3:0] res;
    res = CODE_NOP;
    case (code)
      CODE_ACTIVE, CODE_L1, CODE_L2, CODE_LINKRST, CODE_RETRAIN, CODE_DISABLED: res = code;
      default: res = CODE_NOP;
    endcase
    return res;
  endfunction

  // Priority resolution; PM states only win when every stack agrees on entering PM.
  always_comb begin
    any_dis = 1'b0;
    any_lr  = 1'b0;
    any_rt  = 1'b0;
    any_act = 1'b0;
    all_l2  = 1'b1;
    all_pm  = 1'b1;
    for (int n = 0; n < int'(NUM_STACKS); n++) begin
      any_dis = any_dis | (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_DISABLED);
      any_lr  = any_lr  | (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_LINKRST);
      any_rt  = any_rt  | (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_RETRAIN);
      any_act = any_act | (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_ACTIVE);
      all_l2  = all_l2  & (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_L2);
      all_pm  = all_pm  & ((norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_L1) |
                           (norm_req(bus.i_fdi_lp_state_req[4*n +: 4]) == CODE_L2));
    end
    if (any_dis)      resolved = CODE_DISABLED;
    else if (any_lr)  resolved = CODE_LINKRST;
    else if (any_rt)  resolved = CODE_RETRAIN;
    else if (any_act) resolved = CODE_ACTIVE;
    else if (all_l2)  resolved = CODE_L2;
    else if (all_pm)  resolved = CODE_L1;
    else              resolved = CODE_NOP;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      target <= CODE_NOP;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      target <= target_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state: match beats link error, link error beats timeout.
  always_comb begin
    state_n   = state;
    target_n  = target;
    cnt_n     = cnt;
    done_n    = '0;
    timeout_n = 1'b0;
    case (state)
      S_IDLE: begin
        if ((resolved != CODE_NOP) && (resolved != sts_q)) begin
          state_n  = S_WAIT;
          target_n = resolved;
          cnt_n    = '0;
        end
      end
      S_WAIT: begin
        if (bus.i_rdi_pl_state_sts == target) begin
          state_n  = S_IDLE;
          target_n = CODE_NOP;
          for (int n = 0; n < int'(NUM_STACKS); n++) begin
            done_n[n] = (bus.i_fdi_lp_state_req[4*n +: 4] == target);
          end
        end else if (bus.i_rdi_pl_state_sts == CODE_LINKERR) begin
          state_n  = S_IDLE;
          target_n = CODE_NOP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_n   = S_IDLE;
          target_n  = CODE_NOP;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n  = S_IDLE;
        target_n = CODE_NOP;
      end
    endcase
  end

  // Registered outputs, plus the status copy used for the "already there" check.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sts_q                  <= CODE_NOP;
      bus.o_rdi_lp_state_req <= CODE_NOP;
      bus.o_rdi_lp_linkerror <= 1'b0;
      bus.o_fdi_pl_state_sts <= '0;
      bus.o_req_done         <= '0;
      bus.o_timeout          <= 1'b0;
      bus.o_busy             <= 1'b0;
    end else begin
      sts_q                  <= bus.i_rdi_pl_state_sts;
      bus.o_rdi_lp_state_req <= (state_n == S_WAIT) ? target_n : CODE_NOP;
      bus.o_rdi_lp_linkerror <= |bus.i_fdi_lp_linkerror;
      bus.o_fdi_pl_state_sts <= {NUM_STACKS{bus.i_rdi_pl_state_sts}};
      bus.o_req_done         <= done_n;
      bus.o_timeout          <= timeout_n;
      bus.o_busy             <= (state_n == S_WAIT);
    end
  end

endmodule
